// File: rtl/mdu_seq_if.sv
// Bus between the EX stage and the iterative multiply/divide sequencer.
//   start_i    : EX requests an M op (held with stable operands until ready_o)
//   op_i       : funct3 of the M op
//   opdata1_i  : rs1 value (multiplicand / dividend)
//   opdata2_i  : rs2 value (multiplier / divisor)
//   annul_i    : pipeline flush, aborts the op in flight
//   result_o   : registered result, valid with ready_o and held afterwards
//   ready_o    : one-cycle result-valid pulse
//   stallreq_o : combinational stall request to the pipeline controller
interface mdu_seq_if #(
    parameter int unsigned XLEN = 32
);
    logic            start_i;
    logic [2:0]      op_i;
    logic [XLEN-1:0] opdata1_i;
    logic [XLEN-1:0] opdata2_i;
    logic            annul_i;
    logic [XLEN-1:0] result_o;
    logic            ready_o;
    logic            stallreq_o;

    // EX-stage side
    modport master (
        output start_i, op_i, opdata1_i, opdata2_i, annul_i,
        input  result_o, ready_o, stallreq_o
    );

    // Sequencer side
    modport slave (
        input  start_i, op_i, opdata1_i, opdata2_i, annul_i,
        output result_o, ready_o, stallreq_o
    );
endinterface

// File: rtl/mdu_seq.sv
// Iterative RV32M multiply/divide sequencer beside the EX-stage ALU.
// Ports:
//   clk : system clock, rising edge
//   rst : asynchronous active-high reset
//   bus : mdu_seq_if.slave (start/op/operands/annul in; result/ready/stall out)
// Multiplies run 32 shift-add steps on operand magnitudes, divides run 32
// restoring steps; signs are applied when the last step is loaded.
module mdu_seq #(
    parameter int unsigned XLEN = 32
) (
    input  logic      clk,
    input  logic      rst,
    mdu_seq_if.slave  bus
);
    localparam int unsigned PW = 2 * XLEN;
    localparam int unsigned CW = 5;
    localparam logic [CW-1:0]   CNT_LAST = CW'(XLEN - 1);
    localparam logic [XLEN-1:0] MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t          state_q, state_nxt;
    logic [CW-1:0]   cnt_q;
    logic [PW-1:0]   acc_q;       // mul: {partial product, multiplier}; div: {remainder, dividend/quotient}
    logic [XLEN-1:0] b_q;         // mul: multiplicand magnitude; div: divisor magnitude
    logic [2:0]      op_q;
    logic            neg_q;       // product / quotient sign
    logic            s1_q;        // remainder sign
    logic [XLEN-1:0] result_q;

    logic            accept;
    logic            s1_in, s2_in;
    logic            div_zero, div_ovf, special;
    logic [XLEN-1:0] mag1, mag2, special_res;

    logic [XLEN:0]   mul_sum;
    logic [XLEN:0]   div_sh;
    logic            div_ok;
    logic [XLEN-1:0] div_diff;
    logic [PW-1:0]   step, prod;
    logic [XLEN-1:0] quo, rem, final_res;

    assign bus.result_o = result_q;
    assign bus.ready_o  = (state_q == DONE) & ~bus.annul_i;

    // Operand decode: signedness, magnitudes and divide special cases
    always_comb begin
        accept   = (state_q == IDLE) & bus.start_i & ~bus.annul_i;
        s1_in    = bus.opdata1_i[XLEN-1] & (bus.op_i inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b110});
        s2_in    = bus.opdata2_i[XLEN-1] & (bus.op_i inside {3'b000, 3'b001, 3'b100, 3'b110});
        // 0x80000000 negates to itself, which is the correct unsigned magnitude
        mag1     = s1_in ? (~bus.opdata1_i + XLEN'(1)) : bus.opdata1_i;
        mag2     = s2_in ? (~bus.opdata2_i + XLEN'(1)) : bus.opdata2_i;
        div_zero = bus.op_i[2] & (bus.opdata2_i == '0);
        div_ovf  = bus.op_i[2] & ~bus.op_i[0] & (bus.opdata1_i == MIN_NEG) & (bus.opdata2_i == '1);
        special  = div_zero | div_ovf;
        if (div_zero)
            special_res = bus.op_i[1] ? bus.opdata1_i : '1;
        else
            special_res = bus.op_i[1] ? '0 : MIN_NEG;
    end

    // One iteration step and sign-corrected result of the final step
    always_comb begin
        mul_sum  = {1'b0, acc_q[PW-1:XLEN]} + (acc_q[0] ? {1'b0, b_q} : {(XLEN+1){1'b0}});
        div_sh   = {acc_q[PW-1:XLEN], acc_q[XLEN-1]};
        div_ok   = div_sh >= {1'b0, b_q};
        // remainder stays below the divisor, so the difference fits in XLEN bits
        div_diff = div_sh[XLEN-1:0] - b_q;
        if (op_q[2])
            step = div_ok ? {div_diff, acc_q[XLEN-2:0], 1'b1}
                          : {div_sh[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
        else
            step = {mul_sum, acc_q[XLEN-1:1]};
        prod = neg_q ? (~step + PW'(1)) : step;
        quo  = neg_q ? (~step[XLEN-1:0] + XLEN'(1)) : step[XLEN-1:0];
        rem  = s1_q ? (~step[PW-1:XLEN] + XLEN'(1)) : step[PW-1:XLEN];
        case (op_q)
            3'b000:                 final_res = prod[XLEN-1:0];
            3'b001, 3'b010, 3'b011: final_res = prod[PW-1:XLEN];
            3'b100, 3'b101:         final_res = quo;
            default:                final_res = rem;
        endcase
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_nxt;
    end

    // Next state and stall request
    always_comb begin
        state_nxt      = state_q;
        bus.stallreq_o = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_nxt      = special ? DONE : RUN;
                    bus.stallreq_o = 1'b1;
                end
            end
            RUN: begin
                bus.stallreq_o = 1'b1;
                if (cnt_q == CNT_LAST) state_nxt = DONE;
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (bus.annul_i) begin
            state_nxt      = IDLE;
            bus.stallreq_o = 1'b0;
        end
        if (rst) bus.stallreq_o = 1'b0;
    end

    // Datapath registers; a flush leaves everything, including result_o, untouched
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q    <= '0;
            acc_q    <= '0;
            b_q      <= '0;
            op_q     <= '0;
            neg_q    <= 1'b0;
            s1_q     <= 1'b0;
            result_q <= '0;
        end else if (!bus.annul_i) begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        op_q  <= bus.op_i;
                        s1_q  <= s1_in;
                        neg_q <= s1_in ^ s2_in;
                        acc_q <= {{XLEN{1'b0}}, bus.op_i[2] ? mag1 : mag2};
                        b_q   <= bus.op_i[2] ? mag2 : mag1;
                        cnt_q <= '0;
                        if (special) result_q <= special_res;
                    end
                end
                RUN: begin
                    acc_q <= step;
                    cnt_q <= cnt_q + CW'(1);
                    if (cnt_q == CNT_LAST) result_q <= final_res;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_mdu_seq.sv
// Scoreboard bench for mdu_seq: the driver pushes hand-computed results and
// latencies, a monitor pops and compares on every ready_o pulse.
module tb_mdu_seq;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mdu_seq_if bus ();
    mdu_seq dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct {
        logic [31:0] res;
        int          lat;
        int          t0;
        string       nm;
    } exp_t;

    typedef struct {
        string       nm;
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] r;
        int          lat;
    } vec_t;

    exp_t        sb[$];
    vec_t        vecs[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc    = 0;
    logic [31:0] last_res;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Monitor: every ready pulse must match the oldest expected response
    always @(negedge clk) begin
        exp_t e;
        if (!rst && bus.ready_o === 1'b1) begin
            if (sb.size() == 0) begin
                chk("unexpected_ready", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                chk({e.nm, "_result"}, bus.result_o, e.res);
                chk({e.nm, "_latency"}, 32'(cyc - e.t0), 32'(e.lat));
            end
        end
    end

    // Issue one op; start_i stays high afterwards so a following call is back-to-back
    task automatic do_op(input string nm, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] r, input int lat);
        bit got;
        bit stall_bad;
        @(posedge clk);
        #1;
        bus.start_i   = 1'b1;
        bus.op_i      = op;
        bus.opdata1_i = a;
        bus.opdata2_i = b;
        sb.push_back('{r, lat, cyc, nm});
        got       = 1'b0;
        stall_bad = 1'b0;
        for (int n = 0; n < 40 && !got; n++) begin
            @(negedge clk);
            if (bus.ready_o === 1'b1) begin
                chk({nm, "_stall_in_done"}, 32'(bus.stallreq_o), 32'd0);
                got = 1'b1;
            end else if (bus.stallreq_o !== 1'b1) begin
                stall_bad = 1'b1;
            end
        end
        chk({nm, "_stall_held"}, 32'(stall_bad), 32'd0);
        if (!got) chk({nm, "_timeout"}, 32'd0, 32'd1);
        last_res = r;
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        bus.start_i   = 1'b1;
        bus.op_i      = 3'b000;
        bus.opdata1_i = 32'd7;
        bus.opdata2_i = 32'd9;
        bus.annul_i   = 1'b0;
        last_res      = '0;

        vecs.push_back('{"mul_7_m3",      3'b000, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 33});
        vecs.push_back('{"mulhu_m1_m1",   3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 33});
        vecs.push_back('{"mulh_m1_m1",    3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 33});
        vecs.push_back('{"mulhsu_m1_m1",  3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 33});
        vecs.push_back('{"mulh_min_min",  3'b001, 32'h80000000, 32'h80000000, 32'h40000000, 33});
        vecs.push_back('{"mul_x_0",       3'b000, 32'h12345678, 32'h00000000, 32'h00000000, 33});
        vecs.push_back('{"div_m7_2",      3'b100, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 33});
        vecs.push_back('{"rem_m7_2",      3'b110, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 33});
        vecs.push_back('{"divu_100_7",    3'b101, 32'd100,      32'd7,        32'd14,       33});
        vecs.push_back('{"remu_100_7",    3'b111, 32'd100,      32'd7,        32'd2,        33});
        vecs.push_back('{"divu_by0",      3'b101, 32'h1234,     32'd0,        32'hFFFFFFFF, 1});
        vecs.push_back('{"remu_by0",      3'b111, 32'h1234,     32'd0,        32'h00001234, 1});
        vecs.push_back('{"div_ovf",       3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1});
        vecs.push_back('{"rem_ovf",       3'b110, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1});
        vecs.push_back('{"div_m5_by0",    3'b100, 32'hFFFFFFFB, 32'd0,        32'hFFFFFFFF, 1});
        vecs.push_back('{"rem_m5_by0",    3'b110, 32'hFFFFFFFB, 32'd0,        32'hFFFFFFFB, 1});

        // Reset state, with start_i high to show stall is masked by rst
        #12;
        chk("rst_result", bus.result_o, 32'd0);
        chk("rst_ready", 32'(bus.ready_o), 32'd0);
        chk("rst_stall", 32'(bus.stallreq_o), 32'd0);
        bus.start_i = 1'b0;
        @(negedge clk);
        rst = 1'b0;

        // Directed vectors, issued back to back
        foreach (vecs[i])
            do_op(vecs[i].nm, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].r, vecs[i].lat);
        @(posedge clk);
        #1;
        bus.start_i = 1'b0;
        repeat (3) @(posedge clk);

        // Flush in cycle 10 of a divide
        #1;
        bus.start_i   = 1'b1;
        bus.op_i      = 3'b100;
        bus.opdata1_i = 32'd1000;
        bus.opdata2_i = 32'd3;
        repeat (10) @(posedge clk);
        #1;
        bus.annul_i = 1'b1;
        #1;
        chk("annul_stall_drop", 32'(bus.stallreq_o), 32'd0);
        @(posedge clk);
        #1;
        bus.annul_i = 1'b0;
        bus.start_i = 1'b0;
        repeat (40) @(negedge clk);
        chk("annul_result_held", bus.result_o, last_res);
        chk("annul_idle_stall", 32'(bus.stallreq_o), 32'd0);
        do_op("mul_3_5_after_annul", 3'b000, 32'd3, 32'd5, 32'd15, 33);
        @(posedge clk);
        #1;
        bus.start_i = 1'b0;
        repeat (2) @(posedge clk);

        // Asynchronous reset mid-RUN
        #1;
        bus.start_i   = 1'b1;
        bus.op_i      = 3'b000;
        bus.opdata1_i = 32'h1234;
        bus.opdata2_i = 32'h5678;
        repeat (5) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        chk("async_rst_result", bus.result_o, 32'd0);
        chk("async_rst_ready", 32'(bus.ready_o), 32'd0);
        chk("async_rst_stall", 32'(bus.stallreq_o), 32'd0);
        bus.start_i = 1'b0;
        @(negedge clk);
        rst = 1'b0;

        // Back-to-back ops after reset
        do_op("mulhu_2p16_sq", 3'b011, 32'h00010000, 32'h00010000, 32'h00000001, 33);
        do_op("mul_2p16_sq",   3'b000, 32'h00010000, 32'h00010000, 32'h00000000, 33);
        do_op("divu_1000_3",   3'b101, 32'd1000,     32'd3,        32'd333,      33);
        @(posedge clk);
        #1;
        bus.start_i = 1'b0;
        repeat (3) @(negedge clk);
        chk("scoreboard_empty", 32'(sb.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/mdu_seq.md
Name: mdu_seq

Overview:
- Iterative RV32M multiply/divide sequencer that sits beside the EX-stage ALU.
- When EX decodes an M-extension op, it asserts start_i with both operands. This block then holds the pipeline through stallreq_o while it iterates for 32 cycles, and presents a registered result with a one-cycle ready_o.
- EX muxes result_o into wdata_o on the cycle ready_o is high.
- A flush input (annul_i) aborts any operation in flight.

Parameters:
- XLEN, 32, operand/result width. Only 32 is supported. The iteration counter is 5 bits.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- start_i  in  1  EX requests an M op; held high with stable operands until ready_o
- op_i  in  3  funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- opdata1_i  in  32  rs1 value (multiplicand / dividend)
- opdata2_i  in  32  rs2 value (multiplier / divisor)
- annul_i  in  1  flush; aborts the current op
- result_o  out  32  registered result, valid when ready_o=1, held afterwards
- ready_o  out  1  one-cycle pulse, result valid
- stallreq_o  out  1  combinational stall request to the pipeline controller

Behaviour:
- Reset (async, rst=1): state=IDLE, cnt=0, result_o=0, ready_o=0, all internal regs=0. stallreq_o=0 while rst=1. Reset mid-operation discards the op.
- States: IDLE, RUN, DONE.
- IDLE:
  - If start_i=1 and annul_i=0: latch op_i, |opdata1_i|, |opdata2_i| and the sign flags.
  - Normal ops go to RUN with cnt=0.
  - Special divide cases load the result directly and go to DONE.
- RUN: one shift-add (MUL*) or one restore-subtract (DIV*/REM*) step per cycle. cnt increments each cycle. At cnt=31, sign-correct, load result_o and go to DONE.
- DONE: ready_o=1 for exactly this cycle, then go to IDLE unconditionally. start_i is ignored in DONE; the pipeline advances on this cycle, so start_i in the following IDLE cycle belongs to the next instruction.
- Latency: start accepted in cycle 0 -> RUN in cycles 1..32 -> DONE (ready_o) in cycle 33. Special cases: DONE in cycle 1.
- stallreq_o = (IDLE & start_i & ~annul_i) | RUN. It is 0 in DONE.
- annul_i=1 in any state: go to IDLE next edge, ready_o=0, result_o unchanged, stallreq_o=0 immediately. annul_i together with start_i in IDLE: annul wins, nothing latched.
- Signedness:
  - MUL/MULH/DIV/REM treat both operands as signed.
  - MULHSU treats op1 as signed and op2 as unsigned.
  - MULHU/DIVU/REMU treat both as unsigned.
- Iteration and sign correction:
  - Iterate on unsigned magnitudes using a 64-bit product register or a 33-bit partial remainder.
  - Product sign = s1^s2; negate the 64-bit product if set.
  - Quotient sign = s1^s2. Remainder sign = s1.
- Result selection:
  - MUL: product[31:0].
  - MULH/MULHSU/MULHU: product[63:32].
- Special cases (no iteration):
  - Divisor = 0: DIV/DIVU -> 0xFFFFFFFF; REM/REMU -> opdata1_i.
  - Signed overflow (0x80000000 / 0xFFFFFFFF): DIV -> 0x80000000; REM -> 0.
  - Multiply has no special cases; x*0 iterates normally.
- Magnitude of 0x80000000 is handled as 33-bit unsigned (no overflow in abs).
- All arithmetic wraps modulo 2^32 at the output. There are no exceptions or flags.

Test Plan:
- MUL 7 * 0xFFFFFFFD -> stallreq_o high cycles 0..32; ready_o and result_o=0xFFFFFFEB in cycle 33; stallreq_o=0 in cycle 33.
- MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE. MULH same operands -> 0x00000000. MULHSU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFF.
- DIV 0xFFFFFFF9 / 2 -> 0xFFFFFFFD. REM same -> 0xFFFFFFFF. DIVU 100/7 -> 14. REMU 100/7 -> 2.
- DIVU 0x1234/0 -> 0xFFFFFFFF with ready_o in cycle 1. REMU 0x1234/0 -> 0x1234. DIV 0x80000000/0xFFFFFFFF -> 0x80000000 in cycle 1. REM same -> 0.
- annul_i pulse at cycle 10 of a DIV -> stallreq_o drops that cycle, no ready_o, FSM IDLE. The next MUL 3*5 -> 15 at its cycle 33.
- rst asserted asynchronously mid-RUN -> outputs 0 immediately. Back-to-back ops after reset: start_i in the cycle following DONE is accepted as a new op.
